// File: rtl/dmem_load_arbiter_pkg.sv
// Shared types and defaults for the data-memory load arbiter.
package dmem_load_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W     = 4;
   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_STARVE_MAX = 4;
   localparam int unsigned BYTE_W         = 8;

   // Little-endian stream: the first byte received fills the low half of the word.
   localparam bit FIRST_BYTE_LOW = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      PEND = 3'd3,
      DONE = 3'd4
   } state_e;

endpackage

// File: rtl/dmem_byte_packer.sv
// Assembles two UART bytes into one memory word and owns the rx handshake.
module dmem_byte_packer
   import dmem_load_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_lo,
   input  logic              in_hi,
   input  logic              accept_d,
   input  logic              abort,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_byte,
   output logic              rx_ready,
   output logic              byte_xfer_c,
   output logic              word_valid_c,
   output logic [DATA_W-1:0] word_data
);

   localparam int unsigned HALF_W = DATA_W / 2;

   logic              rx_ready_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // An abort in the same cycle wins over the byte transfer.
   assign byte_xfer_c  = rx_valid & rx_ready_q & ~abort;
   assign word_valid_c = byte_xfer_c & in_hi;
   assign rx_ready     = rx_ready_q;
   assign word_data    = data_q;

   // Steer the accepted byte into the half selected by the current byte phase.
   always_comb begin
      data_d = data_q;
      if (byte_xfer_c && (in_lo || in_hi)) begin
         if (in_lo == FIRST_BYTE_LOW) begin
            data_d[HALF_W-1:0] = HALF_W'(rx_byte);
         end else begin
            data_d[DATA_W-1:HALF_W] = HALF_W'(rx_byte);
         end
      end
   end

   // Word register and registered ready flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_ready_q <= 1'b0;
         data_q     <= '0;
      end else begin
         rx_ready_q <= accept_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: rtl/dmem_load_arbiter.sv
// Shares the data-memory write port between the CPU and a UART word loader.
module dmem_load_arbiter
   import dmem_load_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_len,
   input  logic              load_abort,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_byte,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              load_busy,
   output logic              load_done
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              load_busy_q, load_busy_d;
   logic              load_done_q, load_done_d;
   logic              cpu_stall_q, cpu_stall_d;
   logic              accept_d;
   logic              starved_c;
   logic              loader_wr_c;
   logic              byte_xfer_c;
   logic              word_valid_c;
   logic [DATA_W-1:0] word_data;

   dmem_byte_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk          (clk),
      .reset        (reset),
      .in_lo        (state_q == LO),
      .in_hi        (state_q == HI),
      .accept_d     (accept_d),
      .abort        (load_abort),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .rx_ready     (rx_ready),
      .byte_xfer_c  (byte_xfer_c),
      .word_valid_c (word_valid_c),
      .word_data    (word_data)
   );

   // Next-state, counters and the loader-write decision.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      word_cnt_d  = word_cnt_q;
      addr_d      = addr_q;
      loader_wr_c = 1'b0;
      starved_c   = (wait_cnt_q == CNT_W'(STARVE_MAX));

      case (state_q)
         IDLE: begin
            if (load_start) begin
               if (load_len != '0) begin
                  state_d    = LO;
                  addr_d     = load_base;
                  word_cnt_d = load_len;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LO: begin
            if (load_abort) begin
               state_d = IDLE;
            end else if (byte_xfer_c) begin
               state_d = HI;
            end
         end
         HI: begin
            if (load_abort) begin
               state_d = IDLE;
            end else if (word_valid_c) begin
               state_d = PEND;
            end
         end
         PEND: begin
            if (load_abort) begin
               state_d = IDLE;
            end else if (!cpu_we || starved_c) begin
               // Loader takes the port: idle CPU, or CPU stalled after starvation.
               loader_wr_c = 1'b1;
               addr_d      = addr_q + ADDR_W'(1);
               word_cnt_d  = word_cnt_q - (ADDR_W + 1)'(1);
               state_d     = (word_cnt_q == (ADDR_W + 1)'(1)) ? DONE : LO;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The starvation count only lives while a word is waiting.
      if (state_d != PEND || loader_wr_c) begin
         wait_cnt_d = '0;
      end

      load_busy_d = (state_d != IDLE);
      load_done_d = (state_d == DONE);
      cpu_stall_d = (state_d == PEND) && (wait_cnt_d == CNT_W'(STARVE_MAX));
      accept_d    = (state_d == LO) || (state_d == HI);
   end

   // Memory port: CPU pass-through except in a loader write cycle.
   always_comb begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (loader_wr_c) begin
         mem_we    = 1'b1;
         mem_addr  = addr_q;
         mem_wdata = word_data;
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         word_cnt_q  <= '0;
         addr_q      <= '0;
         load_busy_q <= 1'b0;
         load_done_q <= 1'b0;
         cpu_stall_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         word_cnt_q  <= word_cnt_d;
         addr_q      <= addr_d;
         load_busy_q <= load_busy_d;
         load_done_q <= load_done_d;
         cpu_stall_q <= cpu_stall_d;
      end
   end

   assign load_busy = load_busy_q;
   assign load_done = load_done_q;
   assign cpu_stall = cpu_stall_q;

endmodule

// File: tb/tb_dmem_load_arbiter.sv
// Bench for dmem_load_arbiter: directed vector table, reset sequence, random run.
`timescale 1ns/1ps
module tb_dmem_load_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_we;
   logic [3:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_stall;
   logic        load_start;
   logic [3:0]  load_base;
   logic [4:0]  load_len;
   logic        load_abort;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_ready;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        load_busy;
   logic        load_done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_load_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .load_start (load_start),
      .load_base  (load_base),
      .load_len   (load_len),
      .load_abort (load_abort),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .rx_ready   (rx_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   // ctl = {load_start, rx_valid, load_abort}; eflg = {rx_ready, busy, done, stall}
   typedef struct {
      string       tag;
      logic        cpu_we;
      logic [3:0]  cpu_addr;
      logic [15:0] cpu_wdata;
      logic [2:0]  ctl;
      logic [3:0]  base;
      logic [4:0]  len;
      logic [7:0]  rxb;
      logic        e_we;
      logic [3:0]  e_addr;
      logic [15:0] e_wdata;
      logic [3:0]  eflg;
   } vec_t;

   vec_t vecs[$];

   task automatic r(input string t, input logic we, input logic [3:0] a, input logic [15:0] d,
                    input logic [2:0] ctl, input logic [3:0] b, input logic [4:0] l, input logic [7:0] rb,
                    input logic ewe, input logic [3:0] ea, input logic [15:0] ed, input logic [3:0] ef);
      vec_t v;
      v.tag = t; v.cpu_we = we; v.cpu_addr = a; v.cpu_wdata = d; v.ctl = ctl;
      v.base = b; v.len = l; v.rxb = rb; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed; v.eflg = ef;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [24:0] exp);
      logic [24:0] act;
      act = {mem_we, mem_addr, mem_wdata, rx_ready, load_busy, load_done, cpu_stall};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got we=%b addr=%h wdata=%h rdy=%b busy=%b done=%b stall=%b, expected we=%b addr=%h wdata=%h rdy=%b busy=%b done=%b stall=%b",
                  name, $time, act[24], act[23:20], act[19:4], act[3], act[2], act[1], act[0],
                  exp[24], exp[23:20], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk); #1;
      cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      load_start = v.ctl[2]; rx_valid = v.ctl[1]; load_abort = v.ctl[0];
      load_base = v.base; load_len = v.len; rx_byte = v.rxb;
      @(negedge clk);
      check(v.tag, {v.e_we, v.e_addr, v.e_wdata, v.eflg});
   endtask

   // Reference model state for the random run.
   bit         m_active, m_done, m_pend, m_phase, heavy;
   int         m_left, m_block;
   logic [3:0] m_addr;
   logic [7:0] m_lo;
   logic [15:0] m_word;

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "timeout");
   end

   initial begin : main
      reset = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      load_start = 1'b0; load_base = '0; load_len = '0; load_abort = 1'b0;
      rx_valid = 1'b0; rx_byte = '0;
      repeat (2) @(negedge clk);
      check("reset", 25'd0);
      #1 reset = 1'b1;

      // Basic load: base 3, two words, little-endian bytes
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b100,4'h3,5'd2,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h34, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h12, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h3,16'h1234, 4'b0100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h78, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h56, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h4,16'h5678, 4'b0100);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0110);
      r("basic", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      // Address wrap: 0xF then 0x0
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b100,4'hF,5'd2,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h01, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'hA0, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'hF,16'hA001, 4'b0100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h02, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'hB0, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h0,16'hB002, 4'b0100);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0110);
      r("wrap",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      // Starvation: CPU keeps the port 4 cycles, 5th cycle stall + loader write
      r("starve", 1'b0,4'h7,16'hAAAA, 3'b100,4'h2,5'd1,8'h00, 1'b0,4'h7,16'hAAAA, 4'b0000);
      r("starve", 1'b0,4'h7,16'hAAAA, 3'b010,4'h0,5'd0,8'hCD, 1'b0,4'h7,16'hAAAA, 4'b1100);
      r("starve", 1'b0,4'h7,16'hAAAA, 3'b010,4'h0,5'd0,8'hAB, 1'b0,4'h7,16'hAAAA, 4'b1100);
      for (int i = 0; i < SMAX; i++)
         r("starve", 1'b1,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h7,16'hAAAA, 4'b0100);
      r("starve", 1'b1,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h2,16'hABCD, 4'b0101);
      r("starve", 1'b1,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h7,16'hAAAA, 4'b0110);
      r("starve", 1'b0,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h7,16'hAAAA, 4'b0000);
      // Brief contention: two CPU cycles, loader writes on the third, no stall
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b100,4'h5,5'd1,8'h00, 1'b0,4'h7,16'hAAAA, 4'b0000);
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b010,4'h0,5'd0,8'h11, 1'b0,4'h7,16'hAAAA, 4'b1100);
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b010,4'h0,5'd0,8'h22, 1'b0,4'h7,16'hAAAA, 4'b1100);
      r("brief", 1'b1,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h7,16'hAAAA, 4'b0100);
      r("brief", 1'b1,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h7,16'hAAAA, 4'b0100);
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h5,16'h2211, 4'b0100);
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h7,16'hAAAA, 4'b0110);
      r("brief", 1'b0,4'h7,16'hAAAA, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h7,16'hAAAA, 4'b0000);
      // Abort during word 2 of 3; then a new load is accepted and aborted in LO
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b100,4'h8,5'd3,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h01, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h02, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h8,16'h0201, 4'b0100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b010,4'h0,5'd0,8'h03, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b011,4'h0,5'd0,8'h04, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b100,4'h0,5'd1,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b011,4'h0,5'd0,8'h55, 1'b0,4'h9,16'hBEEF, 4'b1100);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("abort", 1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      // Zero length: done one cycle later, no loader write
      r("zero",  1'b0,4'h9,16'hBEEF, 3'b100,4'h6,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      r("zero",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0110);
      r("zero",  1'b0,4'h9,16'hBEEF, 3'b000,4'h0,5'd0,8'h00, 1'b0,4'h9,16'hBEEF, 4'b0000);
      // Lead-in for the reset-in-PEND sequence: word 0x7766 held off by the CPU
      r("rst_pre", 1'b0,4'h6,16'h5555, 3'b100,4'h1,5'd1,8'h00, 1'b0,4'h6,16'h5555, 4'b0000);
      r("rst_pre", 1'b0,4'h6,16'h5555, 3'b010,4'h0,5'd0,8'h66, 1'b0,4'h6,16'h5555, 4'b1100);
      r("rst_pre", 1'b0,4'h6,16'h5555, 3'b010,4'h0,5'd0,8'h77, 1'b0,4'h6,16'h5555, 4'b1100);
      r("rst_pre", 1'b1,4'h6,16'h5555, 3'b000,4'h0,5'd0,8'h00, 1'b1,4'h6,16'h5555, 4'b0100);

      foreach (vecs[i]) apply(vecs[i]);

      // Asynchronous reset while a word is pending: no loader write, outputs cleared
      #2 reset = 1'b0; cpu_we = 1'b0;
      #1 check("rst_async", {1'b0, 4'h6, 16'h5555, 4'b0000});
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_hold", {1'b0, 4'h6, 16'h5555, 4'b0000});
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("rst_after", {1'b0, 4'h6, 16'h5555, 4'b0000});
      end

      // Random run against a transaction-level model
      m_active = 0; m_done = 0; m_pend = 0; m_phase = 0; heavy = 0;
      m_left = 0; m_block = 0; m_addr = '0; m_lo = '0; m_word = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit wr, xfer, idle, done_n;
         @(posedge clk); #1;
         idle = !m_active && !m_done;
         load_start = idle ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
         load_base  = 4'($urandom);
         load_len   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 16));
         load_abort = 1'b0;
         rx_valid   = ($urandom_range(0, 3) != 0);
         rx_byte    = 8'($urandom);
         cpu_we     = heavy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 4) == 0);
         cpu_addr   = 4'($urandom);
         cpu_wdata  = 16'($urandom);
         @(negedge clk);
         wr = m_pend && (!cpu_we || m_block == SMAX);
         check("rand", {wr ? 1'b1 : cpu_we, wr ? m_addr : cpu_addr, wr ? m_word : cpu_wdata,
                        m_active && !m_pend, m_active || m_done, m_done, m_pend && (m_block == SMAX)});
         xfer   = rx_valid && m_active && !m_pend;
         done_n = 0;
         if (wr) begin
            m_addr  = m_addr + 4'd1;
            m_left  = m_left - 1;
            m_pend  = 0;
            m_block = 0;
            if (m_left == 0) begin
               m_active = 0;
               done_n   = 1;
            end
         end else if (m_pend) begin
            m_block++;
         end
         if (xfer) begin
            if (!m_phase) begin
               m_lo    = rx_byte;
               m_phase = 1;
            end else begin
               m_word  = {rx_byte, m_lo};
               m_phase = 0;
               m_pend  = 1;
            end
         end
         if (idle && load_start) begin
            if (load_len == 5'd0) begin
               done_n = 1;
            end else begin
               m_active = 1;
               m_left   = int'(load_len);
               m_addr   = load_base;
               m_phase  = 0;
               heavy    = ($urandom_range(0, 1) == 1);
            end
         end
         m_done = done_n;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
